// File: rtl/aes_key_expander_if.sv
// Handshake and key bus between the round controller and the AES-128 key expander.
interface aes_key_expander_if;
  logic         START;
  logic [127:0] CIPHER_KEY;
  logic         KEY_READY;
  logic [127:0] ROUND_KEY;
  logic         KEY_VALID;
  logic [3:0]   ROUND_IDX;
  logic         BUSY;
  logic         DONE;

  modport master (
    output START, CIPHER_KEY, KEY_READY,
    input  ROUND_KEY, KEY_VALID, ROUND_IDX, BUSY, DONE
  );

  modport slave (
    input  START, CIPHER_KEY, KEY_READY,
    output ROUND_KEY, KEY_VALID, ROUND_IDX, BUSY, DONE
  );
endinterface

// File: rtl/aes_key_expander.sv
// Iterative AES-128 key schedule: streams round keys 0..10 under valid/ready flow control.
module aes_key_expander (
  input logic              clk,
  input logic              rst_n,
  aes_key_expander_if.slave bus
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StEmit = 1'b1;

  logic [0:0]   state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   idx_q, idx_d;
  logic [7:0]   rcon_q, rcon_d;
  logic         valid_q, valid_d;
  logic         done_q, done_d;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Inverse as x^254 (maps 0 to 0), followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    x252 = gf_mul(x240, x12);
    inv  = gf_mul(x252, x2);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
         ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  logic [31:0]  w0, w1, w2, w3, rot, sub, w4, w5, w6, w7;
  logic [127:0] next_key;

  // Next round key from the current one and the current round constant.
  always_comb begin
    w0  = key_q[127:96];
    w1  = key_q[95:64];
    w2  = key_q[63:32];
    w3  = key_q[31:0];
    rot = {w3[23:0], w3[31:24]};
    sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    w4  = w0 ^ sub ^ {rcon_q, 24'h000000};
    w5  = w1 ^ w4;
    w6  = w2 ^ w5;
    w7  = w3 ^ w6;
    next_key = {w4, w5, w6, w7};
  end

  // Next-state: load on START in idle, advance or finish on each accepted key.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    idx_d   = idx_q;
    rcon_d  = rcon_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.START) begin
          key_d   = bus.CIPHER_KEY;
          idx_d   = 4'd0;
          rcon_d  = 8'h01;
          valid_d = 1'b1;
          state_d = StEmit;
        end
      end
      StEmit: begin
        if (valid_q && bus.KEY_READY) begin
          if (idx_q == 4'd10) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            key_d  = next_key;
            idx_d  = idx_q + 4'd1;
            rcon_d = xtime(rcon_q);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      key_q   <= '0;
      idx_q   <= 4'd0;
      rcon_q  <= 8'h01;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
      rcon_q  <= rcon_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign bus.ROUND_KEY = key_q;
  assign bus.KEY_VALID = valid_q;
  assign bus.ROUND_IDX = idx_q;
  assign bus.BUSY      = (state_q == StEmit);
  assign bus.DONE      = done_q;

endmodule

// File: tb/tb_aes_key_expander.sv
// Self-checking bench for aes_key_expander: known-answer table, random keys against a
// reference key schedule, stalls, ignored START, back-to-back and mid-run reset.
module tb_aes_key_expander;

  logic clk;
  logic rst_n;
  aes_key_expander_if bus ();

  aes_key_expander dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]   sbox_t [256];
  logic [127:0] got [11];

  localparam logic [127:0] FipsKey = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ZeroKey = 128'h0;

  typedef struct {
    logic [127:0] key;
    int           idx;
    logic [127:0] rk;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    int r = 0;
    int x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = x << 1;
      if (x > 255) x = x ^ 'h11b;
    end
    return r[7:0];
  endfunction

  // S-box from first principles: brute-force inverse, then bitwise affine map.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] c = 8'h63;
      logic [7:0] s;
      for (int y = 1; y < 256; y++)
        if (ref_mul(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8]
             ^ inv[(i + 7) % 8] ^ c[i];
      sbox_t[x] = s;
    end
  endtask

  // Textbook 44-word expansion.
  task automatic model_expand(input logic [127:0] key, output logic [127:0] rk [11]);
    logic [31:0] w [44];
    logic [7:0]  rc [11];
    rc[1] = 8'h01;
    for (int r = 2; r <= 10; r++) rc[r] = ref_mul(rc[r - 1], 8'h02);
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      logic [31:0] t = w[i - 1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
        t = t ^ {rc[i / 4], 24'h0};
      end
      w[i] = w[i - 4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
  endtask

  // Runs one expansion from an idle or DONE cycle; returns positioned in the DONE cycle.
  task automatic run_expand(input logic [127:0] key, input int stall_pct, input bit poke);
    logic [127:0] exp [11];
    int seen = 0;
    int cycles = 0;
    bit hs;
    model_expand(key, exp);
    bus.START      = 1'b1;
    bus.CIPHER_KEY = key;
    bus.KEY_READY  = 1'b0;
    @(posedge clk); #1;
    bus.START = 1'b0;
    while (seen <= 10 && cycles < 400) begin
      bus.KEY_READY = ($urandom_range(99) >= stall_pct);
      if (poke) begin
        bus.START      = (cycles == 2);
        bus.CIPHER_KEY = {$urandom, $urandom, $urandom, $urandom};
      end
      check("valid", {127'h0, bus.KEY_VALID}, 128'h1);
      check("busy", {127'h0, bus.BUSY}, 128'h1);
      check("idx", {124'h0, bus.ROUND_IDX}, seen);
      check("round_key", bus.ROUND_KEY, exp[seen]);
      check("done_early", {127'h0, bus.DONE}, 128'h0);
      got[seen] = bus.ROUND_KEY;
      hs = bus.KEY_READY;
      @(posedge clk); #1;
      cycles++;
      if (hs) seen++;
    end
    bus.START = 1'b0;
    if (cycles >= 400) begin
      errors++;
      $display("FAIL timeout: expansion stuck at idx %0d expected 11 keys", seen);
    end
    if (stall_pct == 0) check("done_latency", cycles, 11);
    check("done", {127'h0, bus.DONE}, 128'h1);
    check("busy_done", {127'h0, bus.BUSY}, 128'h0);
    check("valid_done", {127'h0, bus.KEY_VALID}, 128'h0);
  endtask

  task automatic idle_after();
    bus.KEY_READY = 1'b1;
    @(posedge clk); #1;
    check("done_pulse", {127'h0, bus.DONE}, 128'h0);
    check("idle_valid", {127'h0, bus.KEY_VALID}, 128'h0);
    check("idle_busy", {127'h0, bus.BUSY}, 128'h0);
  endtask

  initial begin
    logic [127:0] last;
    int n;
    vecs[0] = '{FipsKey, 0,  FipsKey};
    vecs[1] = '{FipsKey, 1,  128'ha0fafe1788542cb123a339392a6c7605};
    vecs[2] = '{FipsKey, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[3] = '{ZeroKey, 0,  ZeroKey};
    vecs[4] = '{ZeroKey, 1,  128'h62636363626363636263636362636363};
    vecs[5] = '{ZeroKey, 10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};

    build_sbox();
    bus.START      = 1'b0;
    bus.CIPHER_KEY = '0;
    bus.KEY_READY  = 1'b0;
    rst_n = 1'b0;
    #12;
    check("rst_key", bus.ROUND_KEY, 128'h0);
    check("rst_valid", {127'h0, bus.KEY_VALID}, 128'h0);
    check("rst_idx", {124'h0, bus.ROUND_IDX}, 128'h0);
    check("rst_busy", {127'h0, bus.BUSY}, 128'h0);
    check("rst_done", {127'h0, bus.DONE}, 128'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Known-answer table.
    last = ~FipsKey;
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].key !== last) begin
        run_expand(vecs[i].key, 0, 1'b0);
        idle_after();
        last = vecs[i].key;
      end
      check($sformatf("kat_%0d", i), got[vecs[i].idx], vecs[i].rk);
    end

    // FIPS key with random stalls, then START pokes while busy.
    run_expand(FipsKey, 50, 1'b0);
    idle_after();
    run_expand(FipsKey, 30, 1'b1);
    idle_after();

    // Random keys with random stalls.
    for (int k = 0; k < 6; k++) begin
      run_expand({$urandom, $urandom, $urandom, $urandom}, 40, 1'b0);
      idle_after();
    end

    // Back-to-back: START in the DONE cycle.
    run_expand(FipsKey, 0, 1'b0);
    run_expand(ZeroKey, 0, 1'b0);
    idle_after();

    // Reset while idx 5 is presented.
    bus.START      = 1'b1;
    bus.CIPHER_KEY = FipsKey;
    bus.KEY_READY  = 1'b1;
    @(posedge clk); #1;
    bus.START = 1'b0;
    n = 0;
    while (bus.ROUND_IDX != 4'd5 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("reach_idx5", {124'h0, bus.ROUND_IDX}, 128'd5);
    rst_n = 1'b0;
    #1;
    check("mid_rst_key", bus.ROUND_KEY, 128'h0);
    check("mid_rst_valid", {127'h0, bus.KEY_VALID}, 128'h0);
    check("mid_rst_idx", {124'h0, bus.ROUND_IDX}, 128'h0);
    check("mid_rst_busy", {127'h0, bus.BUSY}, 128'h0);
    check("mid_rst_done", {127'h0, bus.DONE}, 128'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check("post_rst_valid", {127'h0, bus.KEY_VALID}, 128'h0);
    end
    run_expand(FipsKey, 20, 1'b0);
    idle_after();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_key_expander.md
# aes_key_expander

Iterative AES-128 key schedule that expands a 128-bit cipher key into the 11 round keys, one per accepted handshake. It sits beside the MixColumns stage in the round datapath and feeds the AddRoundKey stage, which XORs each round key onto the mixed state. Round keys stream out in order 0..10 under valid/ready flow control, so the round controller can stall the schedule to match datapath latency.

## Interface
- Parameters: none; AES-128 only, 10 rounds fixed.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- START  in  1  request expansion; accepted only when BUSY=0
- CIPHER_KEY  in  128  key, sampled on accepted START; [127:96]=w0 … [31:0]=w3, MSB byte first (same byte/column layout as the state)
- KEY_READY  in  1  consumer accepts ROUND_KEY this cycle
- ROUND_KEY  out  128  current round key, same layout as CIPHER_KEY
- KEY_VALID  out  1  ROUND_KEY/ROUND_IDX valid
- ROUND_IDX  out  4  index of ROUND_KEY, 0..10
- BUSY  out  1  expansion in progress (state EMIT)
- DONE  out  1  one-cycle pulse after round key 10 is accepted

## Operation
- States: IDLE, EMIT. Reset → IDLE.
- IDLE: START=1 → load ROUND_KEY<=CIPHER_KEY, ROUND_IDX<=0, RCON<=8'h01, KEY_VALID<=1, go to EMIT.
- EMIT, handshake (KEY_VALID & KEY_READY):
  - ROUND_IDX<10: ROUND_KEY<=next(ROUND_KEY, RCON), ROUND_IDX<=ROUND_IDX+1, RCON<=xtime(RCON) (×2 mod 0x11b).
  - ROUND_IDX==10: KEY_VALID<=0, DONE<=1 for one cycle, go to IDLE.
- EMIT, no handshake: ROUND_KEY, ROUND_IDX, RCON, KEY_VALID hold unchanged.
- next(): w4=w0^SubWord(RotWord(w3))^{RCON,24'h0}; w5=w1^w4; w6=w2^w5; w7=w3^w6.
  - RotWord({a,b,c,d})={b,c,d,a}; SubWord applies the AES S-box per byte.
- RCON sequence across rounds 1..10: 01,02,04,08,10,20,40,80,1b,36.
- S-box is internal combinational logic (GF(2^8) inverse mod 0x11b, 0→0, then affine transform with constant 0x63); no external module, no ROM init file.
- START while BUSY=1: ignored; CIPHER_KEY not sampled.
- CIPHER_KEY changes after acceptance: no effect on the running expansion.
- KEY_READY while KEY_VALID=0: ignored.

## Timing
- Reset values (rst_n low, asynchronous): state IDLE, ROUND_KEY=0, ROUND_IDX=0, RCON=8'h01, KEY_VALID=0, BUSY=0, DONE=0.
- All outputs registered; no combinational path from any input to any output.
- BUSY = (state==EMIT), registered with the state.
- START accepted at edge T → KEY_VALID=1, ROUND_IDX=0 at T+1.
- With KEY_READY held high: key i presented at T+1+i; key 10 at T+11; DONE=1, BUSY=0, KEY_VALID=0 at T+12.
- Each KEY_READY low cycle during EMIT delays every later key and DONE by one cycle.
- The DONE cycle has BUSY=0, so a START in that cycle is accepted: key 0 of the new expansion is valid the next cycle (back-to-back, no bubble beyond DONE).
- Reset asserted mid-expansion: immediate return to reset values. After release, nothing is emitted until a new START.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, KEY_READY=1 → idx0 = key, idx1=a0fafe1788542cb123a339392a6c7605, idx10=d014f9a8c9ee2589e13f0cc8b6630ca6; DONE exactly at T+12.
- Key 0…0, KEY_READY=1 → idx1=62636363626363636263636362636363, idx10=b4ef5bcb3e92e21123e951cf6f8f188e.
- FIPS key with KEY_READY randomly toggled → ROUND_KEY/ROUND_IDX stable while stalled; same 11-key sequence; DONE only after idx10 is accepted.
- START pulsed with a different key while BUSY → ignored; the original sequence completes unchanged.
- START on the DONE cycle with the zero key → zero-key idx0 valid on the next cycle; full zero-key sequence follows.
- rst_n dropped while idx=5 is presented → all outputs go to reset values immediately; after release KEY_VALID stays 0 until START; a new START restarts at idx0.
